// File: rtl/auth_ctrl_pkg.sv
// auth_ctrl_pkg: shared state encoding, default timing constants and comparator idle key
package auth_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, GRANT, LOCKOUT} state_t;

    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 1024;
    localparam int DEF_GRANT_CYCLES   = 256;

    localparam logic [7:0] CMP_KEY_IDLE = 8'h00;

    // Width needed to hold the larger of the two window lengths minus one.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/auth_cycle_timer.sv
// auth_cycle_timer: loadable down-counter shared by the grant and lockout windows
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_load      : load i_load_val (has priority over i_en)
//   i_load_val  : value loaded on i_load
//   i_en        : decrement by one, saturating at zero
//   o_zero      : counter is zero
module auth_cycle_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_en && r_count != '0)
            r_count <= r_count - W'(1);
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/auth_attempt_controller.sv
// auth_attempt_controller: sequences key attempts into the comparator, grants a bounded window or counts failures and locks out
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_attempt_valid   : key attempt presented; o_attempt_ready high only in IDLE
//   i_attempt_key     : attempted key, driven onto o_cmp_key for exactly one cycle
//   i_cmp_match       : comparator result, sampled during CHECK
//   i_relock          : ends an active grant early
//   o_granted/o_locked: access window / lockout active
//   o_auth_ok/o_auth_fail : one-cycle result pulses
//   o_fail_count      : consecutive failures
module auth_attempt_controller
    import auth_ctrl_pkg::*;
#(
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int GRANT_CYCLES   = DEF_GRANT_CYCLES,
    parameter int FAIL_W         = $clog2(MAX_FAILS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_attempt_valid,
    input  logic [7:0]        i_attempt_key,
    output logic              o_attempt_ready,
    output logic [7:0]        o_cmp_key,
    input  logic              i_cmp_match,
    input  logic              i_relock,
    output logic              o_granted,
    output logic              o_locked,
    output logic              o_auth_ok,
    output logic              o_auth_fail,
    output logic [FAIL_W-1:0] o_fail_count
);

    localparam int TW = timer_width(LOCKOUT_CYCLES, GRANT_CYCLES);

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_cmp_key, w_cmp_key_nxt;
    logic              r_granted, w_granted_nxt;
    logic              r_locked, w_locked_nxt;
    logic              r_auth_ok, w_auth_ok_nxt;
    logic              r_auth_fail, w_auth_fail_nxt;
    logic [FAIL_W-1:0] r_fail_count, w_fail_count_nxt;
    logic [FAIL_W-1:0] w_fail_inc;
    logic              w_load, w_en, w_timer_zero;
    logic [TW-1:0]     w_load_val;

    assign w_fail_inc = r_fail_count + FAIL_W'(1);

    auth_cycle_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_en       (w_en),
        .o_zero     (w_timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cmp_key    <= CMP_KEY_IDLE;
            r_granted    <= 1'b0;
            r_locked     <= 1'b0;
            r_auth_ok    <= 1'b0;
            r_auth_fail  <= 1'b0;
            r_fail_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmp_key    <= w_cmp_key_nxt;
            r_granted    <= w_granted_nxt;
            r_locked     <= w_locked_nxt;
            r_auth_ok    <= w_auth_ok_nxt;
            r_auth_fail  <= w_auth_fail_nxt;
            r_fail_count <= w_fail_count_nxt;
        end
    end

    // The key defaults back to the idle value every cycle, so it only
    // reaches the comparator during the single CHECK cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_cmp_key_nxt    = CMP_KEY_IDLE;
        w_granted_nxt    = r_granted;
        w_locked_nxt     = r_locked;
        w_auth_ok_nxt    = 1'b0;
        w_auth_fail_nxt  = 1'b0;
        w_fail_count_nxt = r_fail_count;
        w_load           = 1'b0;
        w_load_val       = '0;
        w_en             = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_attempt_valid) begin
                    w_cmp_key_nxt = i_attempt_key;
                    w_state_nxt   = CHECK;
                end
            end
            CHECK: begin
                w_load = 1'b1;
                if (i_cmp_match) begin
                    w_auth_ok_nxt    = 1'b1;
                    w_fail_count_nxt = '0;
                    w_load_val       = TW'(GRANT_CYCLES - 1);
                    w_granted_nxt    = 1'b1;
                    w_state_nxt      = GRANT;
                end else begin
                    w_auth_fail_nxt = 1'b1;
                    if (w_fail_inc == FAIL_W'(MAX_FAILS)) begin
                        w_fail_count_nxt = FAIL_W'(MAX_FAILS);
                        w_load_val       = TW'(LOCKOUT_CYCLES - 1);
                        w_locked_nxt     = 1'b1;
                        w_state_nxt      = LOCKOUT;
                    end else begin
                        w_fail_count_nxt = w_fail_inc;
                        w_state_nxt      = IDLE;
                    end
                end
            end
            GRANT: begin
                if (i_relock || w_timer_zero) begin
                    w_granted_nxt = 1'b0;
                    w_state_nxt   = IDLE;
                end else begin
                    w_en = 1'b1;
                end
            end
            LOCKOUT: begin
                if (w_timer_zero) begin
                    w_locked_nxt     = 1'b0;
                    w_fail_count_nxt = '0;
                    w_state_nxt      = IDLE;
                end else begin
                    w_en = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_attempt_ready = (r_state == IDLE);
    assign o_cmp_key       = r_cmp_key;
    assign o_granted       = r_granted;
    assign o_locked        = r_locked;
    assign o_auth_ok       = r_auth_ok;
    assign o_auth_fail     = r_auth_fail;
    assign o_fail_count    = r_fail_count;

endmodule

// File: tb/tb_auth_attempt_controller.sv
// tb_auth_attempt_controller: scoreboard bench for auth_attempt_controller with a comparator accepting 8'hB6
module tb_auth_attempt_controller;

    localparam logic [7:0] KEY  = 8'hB6;
    localparam int         MAXF = 3;

    typedef struct {
        logic       ok;
        logic [1:0] fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_attempt_valid;
    logic [7:0] i_attempt_key;
    logic       o_attempt_ready;
    logic [7:0] o_cmp_key;
    logic       i_cmp_match;
    logic       i_relock;
    logic       o_granted;
    logic       o_locked;
    logic       o_auth_ok;
    logic       o_auth_fail;
    logic [1:0] o_fail_count;

    int   total = 0;
    int   bad = 0;
    int   model_fails = 0;
    exp_t sb[$];
    exp_t mon_e;

    auth_attempt_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_attempt_valid (i_attempt_valid),
        .i_attempt_key   (i_attempt_key),
        .o_attempt_ready (o_attempt_ready),
        .o_cmp_key       (o_cmp_key),
        .i_cmp_match     (i_cmp_match),
        .i_relock        (i_relock),
        .o_granted       (o_granted),
        .o_locked        (o_locked),
        .o_auth_ok       (o_auth_ok),
        .o_auth_fail     (o_auth_fail),
        .o_fail_count    (o_fail_count)
    );

    always #5 clk = ~clk;

    assign i_cmp_match = (o_cmp_key == KEY);

    // Result pulses are popped against the expectations pushed at handshake.
    always @(negedge clk) begin
        if (rst_n && (o_auth_ok || o_auth_fail)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse ok=%0b fail=%0b, none expected", o_auth_ok, o_auth_fail);
            end else begin
                mon_e = sb.pop_front();
                if ({o_auth_ok, o_auth_fail, o_fail_count} !== {mon_e.ok, !mon_e.ok, mon_e.fc}) begin
                    bad++;
                    $display("FAIL result_pulse got ok=%0b fail=%0b fc=%0d want ok=%0b fail=%0b fc=%0d",
                             o_auth_ok, o_auth_fail, o_fail_count, mon_e.ok, !mon_e.ok, mon_e.fc);
                end
            end
        end
    end

    function automatic exp_t push_exp(input logic [7:0] k);
        exp_t e;
        e.ok = (k == KEY);
        model_fails = e.ok ? 0 : ((model_fails + 1 >= MAXF) ? MAXF : model_fails + 1);
        e.fc = 2'(model_fails);
        sb.push_back(e);
        return e;
    endfunction

    task automatic attempt(input logic [7:0] k);
        exp_t e;
        int   n;
        n = 0;
        while (!o_attempt_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!o_attempt_ready) begin
            bad++;
            $display("FAIL ready_timeout got ready=0 want 1 within 2000 cycles");
        end
        e = push_exp(k);
        i_attempt_valid = 1'b1;
        i_attempt_key   = k;
        @(negedge clk);
        i_attempt_valid = 1'b0;
        i_attempt_key   = 8'h5A;
        total++;
        if (o_cmp_key !== k) begin
            bad++;
            $display("FAIL cmp_key_t1 got %h want %h", o_cmp_key, k);
        end
        total++;
        if (o_attempt_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_check got %b want 0", o_attempt_ready);
        end
        @(negedge clk);
        total++;
        if (o_cmp_key !== 8'h00) begin
            bad++;
            $display("FAIL cmp_key_t2 got %h want 00", o_cmp_key);
        end
        total++;
        if (o_fail_count !== e.fc) begin
            bad++;
            $display("FAIL fail_count got %0d want %0d", o_fail_count, e.fc);
        end
        total++;
        if (o_granted !== e.ok) begin
            bad++;
            $display("FAIL granted_t2 got %b want %b", o_granted, e.ok);
        end
        total++;
        if (o_locked !== (!e.ok && model_fails == MAXF)) begin
            bad++;
            $display("FAIL locked_t2 got %b want %b", o_locked, (!e.ok && model_fails == MAXF));
        end
    endtask

    task automatic end_grant();
        i_relock = 1'b1;
        @(negedge clk);
        i_relock = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_attempt_valid = 1'b0;
        i_attempt_key = 8'h00;
        i_relock = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({o_cmp_key, o_granted, o_locked, o_auth_ok, o_auth_fail, o_fail_count} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs got key=%h g=%b l=%b ok=%b f=%b fc=%0d want all 0",
                     o_cmp_key, o_granted, o_locked, o_auth_ok, o_auth_fail, o_fail_count);
        end
        total++;
        if (o_attempt_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got %b want 1", o_attempt_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_grant();
        int n;
        int rb;
        attempt(KEY);
        n = 0;
        rb = 0;
        while (o_granted && n < 400) begin
            n++;
            if (o_attempt_ready || o_fail_count != 0) rb++;
            @(negedge clk);
        end
        total++;
        if (n != 256) begin
            bad++;
            $display("FAIL grant_len got %0d want 256", n);
        end
        total++;
        if (rb != 0) begin
            bad++;
            $display("FAIL grant_ready_fc got %0d bad cycles want 0", rb);
        end
        total++;
        if (o_attempt_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_grant got %b want 1", o_attempt_ready);
        end
    endtask

    task automatic test_lockout();
        int n;
        int rb;
        attempt(8'h00);
        attempt(8'hFF);
        attempt(8'h36);
        i_attempt_valid = 1'b1;
        i_attempt_key = KEY;
        n = 0;
        rb = 0;
        while (o_locked && n < 1200) begin
            n++;
            i_relock = (n == 5);
            if (o_attempt_ready || o_granted) rb++;
            @(negedge clk);
        end
        i_attempt_valid = 1'b0;
        i_relock = 1'b0;
        model_fails = 0;
        total++;
        if (n != 1024) begin
            bad++;
            $display("FAIL lock_len got %0d want 1024", n);
        end
        total++;
        if (rb != 0) begin
            bad++;
            $display("FAIL lock_ready got %0d bad cycles want 0", rb);
        end
        total++;
        if ({o_attempt_ready, o_fail_count} !== 3'b100) begin
            bad++;
            $display("FAIL after_lock got ready=%b fc=%0d want ready=1 fc=0", o_attempt_ready, o_fail_count);
        end
    endtask

    task automatic test_clear_on_success();
        attempt(8'h00);
        attempt(KEY);
        end_grant();
        attempt(8'h11);
        attempt(KEY);
        end_grant();
    endtask

    task automatic test_relock();
        attempt(KEY);
        repeat (9) @(negedge clk);
        i_relock = 1'b1;
        @(negedge clk);
        i_relock = 1'b0;
        total++;
        if ({o_granted, o_attempt_ready} !== 2'b01) begin
            bad++;
            $display("FAIL relock_grant got g=%b ready=%b want g=0 ready=1", o_granted, o_attempt_ready);
        end
        i_relock = 1'b1;
        @(negedge clk);
        i_relock = 1'b0;
        @(negedge clk);
        total++;
        if ({o_granted, o_locked, o_attempt_ready} !== 3'b001) begin
            bad++;
            $display("FAIL relock_idle got g=%b l=%b ready=%b want 0 0 1", o_granted, o_locked, o_attempt_ready);
        end
    endtask

    task automatic test_reset_in_lockout();
        attempt(8'h01);
        attempt(8'h02);
        attempt(8'h03);
        repeat (499) @(negedge clk);
        total++;
        if (o_locked !== 1'b1) begin
            bad++;
            $display("FAIL locked_500 got %b want 1", o_locked);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_locked, o_fail_count, o_cmp_key, o_granted} !== 12'd0) begin
            bad++;
            $display("FAIL async_reset got l=%b fc=%0d key=%h g=%b want all 0", o_locked, o_fail_count, o_cmp_key, o_granted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_fails = 0;
        @(negedge clk);
        attempt(KEY);
        end_grant();
    endtask

    task automatic test_back_to_back();
        int hs;
        int last;
        int dup;
        int n;
        logic [7:0] prevk;
        exp_t e;
        hs = 0;
        last = -10;
        dup = 0;
        prevk = o_cmp_key;
        i_attempt_valid = 1'b1;
        i_attempt_key = 8'h01;
        for (int c = 0; c < 20; c++) begin
            if (o_attempt_ready) begin
                hs++;
                if (hs > 1) begin
                    total++;
                    if (c - last != 2) begin
                        bad++;
                        $display("FAIL b2b_spacing got %0d want 2", c - last);
                    end
                end
                last = c;
                e = push_exp(8'h01);
            end
            @(negedge clk);
            if (prevk == 8'h01 && o_cmp_key == 8'h01) dup++;
            prevk = o_cmp_key;
            if (o_locked) break;
        end
        i_attempt_valid = 1'b0;
        total++;
        if (hs != 3) begin
            bad++;
            $display("FAIL b2b_count got %0d want 3", hs);
        end
        total++;
        if (dup != 0) begin
            bad++;
            $display("FAIL b2b_key_held got %0d want 0", dup);
        end
        n = 0;
        while (o_locked && n < 1200) begin
            n++;
            @(negedge clk);
        end
        model_fails = 0;
        total++;
        if (o_locked !== 1'b0) begin
            bad++;
            $display("FAIL b2b_lock_timeout got locked=%b want 0", o_locked);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_grant();
        test_lockout();
        test_clear_on_success();
        test_relock();
        test_reset_in_lockout();
        test_back_to_back();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/auth_attempt_controller.md
Name: auth_attempt_controller

Overview:
- Sequences key-entry attempts into the scattered key storage comparator: accepts 8-bit key attempts over a valid/ready handshake and presents each attempt to the comparator for exactly one cycle.
- Samples the comparator's match result, then grants access for a bounded window or counts failures.
- Enforces a lockout period after repeated failures.
- Sits between the top-level pin interface and the key comparator; its outputs gate the protected datapath.

Parameters:
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (>=1)
- LOCKOUT_CYCLES, 1024, clock cycles `locked` stays high once lockout is entered (>=1)
- GRANT_CYCLES, 256, clock cycles `granted` stays high after a successful attempt (>=1)
- FAIL_W, $clog2(MAX_FAILS+1), width of the failure counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- attempt_valid  in  1  key attempt presented
- attempt_key  in  8  attempted key value
- attempt_ready  out  1  controller accepts an attempt this cycle
- cmp_key  out  8  drives the comparator's key_input
- cmp_match  in  1  comparator's is_authorized result (combinational from cmp_key)
- relock  in  1  ends an active grant early
- granted  out  1  access window active
- locked  out  1  lockout active
- auth_ok  out  1  one-cycle pulse on a successful check
- auth_fail  out  1  one-cycle pulse on a failed check
- fail_count  out  FAIL_W  current consecutive failures

Behaviour:
- FSM states: IDLE, CHECK, GRANT, LOCKOUT. Reset state is IDLE.
- Reset values: cmp_key=8'h00, fail_count=0, timer=0, granted=0, locked=0, auth_ok=0, auth_fail=0.
- All outputs except attempt_ready are registered. attempt_ready = (state==IDLE), decoded directly from the state register.
- IDLE:
  - A handshake occurs when attempt_valid && attempt_ready in cycle T.
  - On handshake: cmp_key<=attempt_key; next state CHECK.
  - attempt_key is ignored without valid.
- CHECK (exactly one cycle, T+1): cmp_match is sampled. On the next edge cmp_key<=8'h00, so the key is never held on the comparator longer than one cycle.
  - Match:
    - auth_ok=1 for one cycle (T+2).
    - fail_count<=0; timer<=GRANT_CYCLES-1.
    - granted=1 from T+2; next state GRANT.
  - Mismatch: auth_fail=1 for one cycle (T+2).
    - If fail_count+1==MAX_FAILS: fail_count<=MAX_FAILS, timer<=LOCKOUT_CYCLES-1, locked=1 from T+2, next state LOCKOUT.
    - Otherwise: fail_count<=fail_count+1, next state IDLE.
- GRANT:
  - granted=1 for exactly GRANT_CYCLES cycles; timer decrements each cycle.
  - Exit when timer==0, or when relock=1 (relock has priority), to IDLE; granted=0 on the following cycle.
  - attempt_ready=0 throughout, so attempts are not accepted.
- LOCKOUT:
  - locked=1 for exactly LOCKOUT_CYCLES cycles; attempt_ready=0; relock is ignored.
  - At timer==0: next state IDLE, fail_count<=0, locked<=0.
- relock in IDLE, CHECK or LOCKOUT has no effect.
- fail_count never exceeds MAX_FAILS and never wraps.
- Back-to-back attempts: the minimum spacing between accepted attempts is 2 cycles (IDLE, CHECK, IDLE). An attempt_valid held high is accepted again on the first IDLE cycle.
- Reset asserted in any state: every register returns to its reset value immediately. Lockout and grant are not preserved across reset.
- MAX_FAILS=1: the first failure enters LOCKOUT directly.

Decomposition:
- Shared package auth_ctrl_pkg holds:
  - the state enum (IDLE, CHECK, GRANT, LOCKOUT)
  - default constants for MAX_FAILS, LOCKOUT_CYCLES, GRANT_CYCLES
  - the cmp_key idle value 8'h00
- One sub-module, auth_cycle_timer: a loadable down-counter with a load value, load strobe, enable and a zero flag.
  - Shared by GRANT and LOCKOUT.
  - Its width is $clog2(max(LOCKOUT_CYCLES,GRANT_CYCLES)).

Test Plan:
- Reset, then attempt 8'hB6 at cycle T -> cmp_key=8'hB6 only at T+1; auth_ok pulse at T+2; granted high for T+2..T+257 (256 cycles); attempt_ready low throughout; fail_count=0.
- Attempts 8'h00, 8'hFF, 8'h36 -> auth_fail pulse after each; fail_count 1,2,3; locked high for 1024 cycles starting 2 cycles after the third handshake; attempt_valid ignored during lockout; then fail_count=0 and attempt_ready=1.
- Attempts 8'h00, 8'hB6 -> fail_count=1, then 0 with granted=1; a later wrong attempt yields fail_count=1 (the counter was cleared by the success).
- Grant with relock pulsed at granted cycle 10 -> granted falls on the next cycle; state IDLE; attempt_ready=1. relock pulsed in IDLE and during lockout -> no change.
- rst_n asserted at lockout cycle 500 -> locked, fail_count, cmp_key and granted are 0 immediately; an attempt of 8'hB6 after release -> grant.
- attempt_valid held high with 8'h01 -> accepted every 2 cycles until the third failure; cmp_key never equals 8'h01 for two consecutive cycles.
